cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Collects completed results from NUM_FU execution units and broadcasts up to CDB_W of them per cycle on the common data bus.
- The bus drives reservation-station wakeup, the register file and the ROB.
- Holds a small per-FU result FIFO so that a unit which loses arbitration stalls only itself.
- Uses round-robin selection with registered CDB outputs; flush_pipeline empties all FIFOs.

Parameters:
NUM_FU, 4, number of functional-unit result ports
CDB_W, 2, number of CDB broadcast slots per cycle (must be <= NUM_FU)
PHYS_W, 6, physical register tag width
ROB_W, 6, ROB tag width
FIFO_DEPTH, 4, entries per FU result FIFO (power of two, >= 2)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush_pipeline  input  1  discard all buffered and incoming results
fu_valid  input  [NUM_FU]  FU result valid
fu_ready  output  [NUM_FU]  FIFO can accept this cycle
fu_dst_tag  input  [NUM_FU][PHYS_W]  destination physical tag
fu_value  input  [NUM_FU][64]  result value
fu_rob_tag  input  [NUM_FU][ROB_W]  ROB tag of the result
cdb_valid  output  [CDB_W]  broadcast slot valid (registered)
cdb_tag  output  [CDB_W][PHYS_W]  broadcast physical tag (registered)
cdb_value  output  [CDB_W][64]  broadcast value (registered)
cdb_rob_tag  output  [CDB_W][ROB_W]  broadcast ROB tag (registered)

Behaviour:
- Reset (synchronous, active-high; reset takes priority over flush):
  - All FIFOs are emptied, counts are cleared and rr_ptr is set to 0.
  - cdb_valid, cdb_tag, cdb_value and cdb_rob_tag are all 0.
  - fu_ready is forced to 0 while reset is high and reads all-ones in the first cycle after reset.
- Accept:
  - fu_ready[f] = !reset && count[f] < FIFO_DEPTH. It is derived from the registered count only, so a full FIFO is not ready even if it pops in the same cycle.
  - A push occurs when fu_valid[f] && fu_ready[f]. fu_valid while not ready is ignored; the FU must hold its result.
- Arbitration (combinational, on the FIFO heads):
  - Scan FU indices rr_ptr, rr_ptr+1, … mod NUM_FU.
  - The first non-empty FIFO goes to slot 0, the next to slot 1, and so on up to CDB_W slots. Each FU receives at most one grant per cycle.
  - Granted heads pop at the clock edge.
- Output:
  - At each edge, cdb_* load the granted heads. Ungranted slots have cdb_valid=0 and tag/value/rob_tag=0.
  - Minimum latency is one edge: a result accepted at edge t is popped and broadcast at edge t+1, so it is visible from t+1.
  - Results from one FU are broadcast in FIFO order. There is no ordering guarantee across FUs.
- rr_ptr:
  - After any grant, rr_ptr becomes (highest-slot granted FU index + 1) mod NUM_FU.
  - With no grant it is unchanged.
- Simultaneous push and pop on one FIFO: both take effect and the count is unchanged. The pushed entry is never broadcast in its push cycle.
- Flush:
  - At the edge where flush_pipeline=1, all FIFOs empty and cdb_valid becomes 0.
  - Inputs presented in the flush cycle are dropped.
  - rr_ptr is retained.
  - fu_ready is not gated by flush.
- Widths:
  - count[f] is $clog2(FIFO_DEPTH+1) bits.
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.

Optional Feature:
CDB_PERF_EN
- Defined:
  - Adds outputs perf_bcast_cnt[32] (total valid slot-broadcasts) and perf_stall_cnt[32] (cycles where any fu_valid&&!fu_ready).
  - Both counters saturate at all-ones.
  - Both are cleared by reset but not by flush.
- Undefined: neither the ports nor the counter logic exist.

Decomposition:
- core_pkg holds:
  - cdb_entry_t: packed {valid, PHYS_W tag, 64-bit value, ROB_W rob_tag}.
  - Default constants PHYS_W, ROB_W and CDB_W shared with reservation_station and the ROB.
- Sub-module result_fifo (parameter FIFO_DEPTH):
  - Single-clock synchronous FIFO with push, pop, flush, full, empty and head ports.
  - Instantiated NUM_FU times.
- Arbitration and output registers live in cdb_arbiter.

Test Plan:
- Single result: FU0 pushes tag=5, value=0xDEAD, rob=3 at edge t. From t+1: cdb_valid=2'b01, cdb_tag[0]=5, cdb_value[0]=0xDEAD, cdb_rob_tag[0]=3. From t+2: cdb_valid=0.
- Four simultaneous results (tags 1–4 on FU0–3, rr_ptr=0) at edge t: edge t+1 broadcasts {1,2}; edge t+2 broadcasts {3,4}; afterwards rr_ptr=0.
- Fairness: FU0, FU1 and FU2 push every cycle. Grants rotate {0,1}, {2,0}, {1,2}, {0,1}…, with no FU starved for more than one cycle.
- Backpressure: all four FUs push every cycle. The FIFOs fill and fu_ready deasserts at count=4. The bench holds stalled results; all pushed tags appear exactly once and per-FU order is preserved.
- Flush: with 3 entries buffered in FU1 and FU2, assert flush while FU0 pushes tag 9. Next cycle: cdb_valid=0 and fu_ready=4'b1111, and tag 9 never appears.
- Reset mid-stream: assert reset with full FIFOs. fu_ready=0 during reset; afterwards cdb_valid=0, rr_ptr=0, and no stale tag is broadcast.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared core types for the common data bus: broadcast entry layout and the default
// tag/slot widths also used by the reservation stations and the ROB.
package cdb_arbiter_pkg;

  localparam int DEF_PHYS_W     = 6;
  localparam int DEF_ROB_W      = 6;
  localparam int DEF_CDB_W      = 2;
  localparam int DEF_NUM_FU     = 4;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int VALUE_W        = 64;

  typedef struct packed {
    logic [DEF_PHYS_W-1:0] tag;
    logic [VALUE_W-1:0]    value;
    logic [DEF_ROB_W-1:0]  rob_tag;
  } cdb_payload_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_PHYS_W-1:0] tag;
    logic [VALUE_W-1:0]    value;
    logic [DEF_ROB_W-1:0]  rob_tag;
  } cdb_entry_t;

  function automatic cdb_entry_t make_entry(input logic valid, input cdb_payload_t p);
    cdb_entry_t e;
    e.valid   = valid;
    e.tag     = p.tag;
    e.value   = p.value;
    e.rob_tag = p.rob_tag;
    return e;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// FU result handshake and CDB broadcast bundle; master is the FU/consumer side,
// slave is the arbiter.
interface cdb_arbiter_if import cdb_arbiter_pkg::*; #(
  parameter int NUM_FU = DEF_NUM_FU,
  parameter int CDB_W  = DEF_CDB_W,
  parameter int PHYS_W = DEF_PHYS_W,
  parameter int ROB_W  = DEF_ROB_W
);

  logic [NUM_FU-1:0]              fu_valid;
  logic [NUM_FU-1:0]              fu_ready;
  logic [NUM_FU-1:0][PHYS_W-1:0]  fu_dst_tag;
  logic [NUM_FU-1:0][VALUE_W-1:0] fu_value;
  logic [NUM_FU-1:0][ROB_W-1:0]   fu_rob_tag;

  logic [CDB_W-1:0]               cdb_valid;
  logic [CDB_W-1:0][PHYS_W-1:0]   cdb_tag;
  logic [CDB_W-1:0][VALUE_W-1:0]  cdb_value;
  logic [CDB_W-1:0][ROB_W-1:0]    cdb_rob_tag;

  modport master (
    output fu_valid, fu_dst_tag, fu_value, fu_rob_tag,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
  );

  modport slave (
    input  fu_valid, fu_dst_tag, fu_value, fu_rob_tag,
    output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_rob_tag
  );

endinterface

// File: rtl/cdb_arbiter_result_fifo.sv
// Per-FU single-clock result FIFO; reset has priority over flush, and flush drops
// any push or pop presented in the same cycle.
module result_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage is not reset: the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: per-FU result FIFOs feeding CDB_W registered broadcast slots.
// Optional CDB_PERF_EN adds saturating broadcast and stall counters.
module cdb_arbiter import cdb_arbiter_pkg::*; #(
  parameter int NUM_FU     = DEF_NUM_FU,
  parameter int CDB_W      = DEF_CDB_W,
  parameter int PHYS_W     = DEF_PHYS_W,
  parameter int ROB_W      = DEF_ROB_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush_pipeline,
  cdb_arbiter_if.slave bus
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]  perf_bcast_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);

  localparam int RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int PAY_W = PHYS_W + VALUE_W + ROB_W;

  logic [NUM_FU-1:0]  fifo_push, fifo_full, fifo_empty, grant;
  logic [PAY_W-1:0]   fifo_head [NUM_FU];
  logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
  cdb_entry_t [CDB_W-1:0] cdb_q, cdb_d;
  int                 n_slot;

  assign bus.fu_ready = reset ? '0 : ~fifo_full;

  for (genvar f = 0; f < NUM_FU; f++) begin : g_fifo
    assign fifo_push[f] = bus.fu_valid[f] && bus.fu_ready[f];

    result_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .WIDTH      (PAY_W)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush_pipeline),
      .push      (fifo_push[f]),
      .push_data ({bus.fu_dst_tag[f], bus.fu_value[f], bus.fu_rob_tag[f]}),
      .pop       (grant[f]),
      .full      (fifo_full[f]),
      .empty     (fifo_empty[f]),
      .head      (fifo_head[f])
    );
  end

  // Walk FUs from rr_ptr, handing non-empty heads to slots in order until slots run out.
  always_comb begin
    grant    = '0;
    cdb_d    = '0;
    rr_ptr_d = rr_ptr_q;
    n_slot   = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      for (int f = 0; f < NUM_FU; f++) begin
        if ((f == (int'(rr_ptr_q) + i) % NUM_FU) && !fifo_empty[f] && (n_slot < CDB_W)) begin
          grant[f] = 1'b1;
          for (int s = 0; s < CDB_W; s++) begin
            if (s == n_slot) cdb_d[s] = make_entry(1'b1, cdb_payload_t'(fifo_head[f]));
          end
          n_slot   = n_slot + 1;
          rr_ptr_d = RR_W'((f + 1) % NUM_FU);
        end
      end
    end
    if (flush_pipeline) begin
      grant    = '0;
      cdb_d    = '0;
      rr_ptr_d = rr_ptr_q;
      n_slot   = 0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdb_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      cdb_q    <= cdb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar s = 0; s < CDB_W; s++) begin : g_out
    assign bus.cdb_valid[s]   = cdb_q[s].valid;
    assign bus.cdb_tag[s]     = cdb_q[s].tag;
    assign bus.cdb_value[s]   = cdb_q[s].value;
    assign bus.cdb_rob_tag[s] = cdb_q[s].rob_tag;
  end

`ifdef CDB_PERF_EN
  logic [31:0] perf_bcast_q, perf_bcast_d, perf_stall_q, perf_stall_d;
  logic [32:0] bcast_sum;

  // Counters stick at all-ones rather than wrapping; flush leaves them alone.
  always_comb begin
    bcast_sum    = {1'b0, perf_bcast_q} + 33'(n_slot);
    perf_bcast_d = bcast_sum[32] ? '1 : bcast_sum[31:0];
    perf_stall_d = perf_stall_q;
    if (|(bus.fu_valid & ~bus.fu_ready) && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bcast_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_bcast_q <= perf_bcast_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_bcast_cnt = perf_bcast_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized and directed bench for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int NF    = 4;
  localparam int SLOTS = 2;
  localparam int DEPTH = 4;

  typedef struct {
    logic [5:0]  tag;
    logic [63:0] value;
    logic [5:0]  rob;
  } resultT;

  logic clk = 1'b0;
  logic reset;
  logic flushPipeline;

  always #5 clk = ~clk;

  cdb_arbiter_if bus ();

`ifdef CDB_PERF_EN
  logic [31:0] perfBcast, perfStall;
  longint      modelBcast, modelStall;
`endif

  cdb_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .flush_pipeline (flushPipeline),
    .bus            (bus)
`ifdef CDB_PERF_EN
    ,
    .perf_bcast_cnt (perfBcast),
    .perf_stall_cnt (perfStall)
`endif
  );

  resultT     modelQ [NF][$];
  int         modelRr;
  resultT     pend [NF];
  logic [3:0] pendValid;
  int         vectors;
  int         miscompares;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic newResult(input int f);
    pend[f].tag   = 6'($urandom_range(0, 63));
    pend[f].value = {$urandom(), $urandom()};
    pend[f].rob   = 6'($urandom_range(0, 63));
    pendValid[f]  = 1'b1;
  endtask

  // Drive one cycle, advance the reference model, and compare ready and broadcast slots.
  task automatic applyStimulus(input logic rstIn, input logic flushIn);
    logic [3:0]       expReady;
    resultT           expSlot [SLOTS];
    logic [SLOTS-1:0] expValid;
    int               n, last, f;
    logic             stallEvt;

    reset         = rstIn;
    flushPipeline = flushIn;
    bus.fu_valid  = pendValid;
    for (int k = 0; k < NF; k++) begin
      bus.fu_dst_tag[k] = pend[k].tag;
      bus.fu_value[k]   = pend[k].value;
      bus.fu_rob_tag[k] = pend[k].rob;
    end
    #1;

    expValid = '0;
    n        = 0;
    last     = 0;
    for (int s = 0; s < SLOTS; s++) expSlot[s] = '{tag: 6'd0, value: 64'd0, rob: 6'd0};
    if (rstIn) begin
      expReady = '0;
      for (int k = 0; k < NF; k++) modelQ[k].delete();
      modelRr = 0;
    end else begin
      for (int k = 0; k < NF; k++) expReady[k] = (modelQ[k].size() < DEPTH);
      if (flushIn) begin
        for (int k = 0; k < NF; k++) modelQ[k].delete();
      end else begin
        for (int i = 0; i < NF; i++) begin
          f = (modelRr + i) % NF;
          if (modelQ[f].size() > 0 && n < SLOTS) begin
            expSlot[n]  = modelQ[f].pop_front();
            expValid[n] = 1'b1;
            n++;
            last = f;
          end
        end
        for (int k = 0; k < NF; k++) begin
          if (pendValid[k] && expReady[k]) modelQ[k].push_back(pend[k]);
        end
        if (n > 0) modelRr = (last + 1) % NF;
      end
    end
    stallEvt = |(pendValid & ~expReady);

    checkOutput("fu_ready", 64'(bus.fu_ready), 64'(expReady));
    for (int k = 0; k < NF; k++) begin
      if (pendValid[k] && expReady[k]) pendValid[k] = 1'b0;
    end

    @(posedge clk);
    #1;
    checkOutput("cdb_valid", 64'(bus.cdb_valid), 64'(expValid));
    for (int s = 0; s < SLOTS; s++) begin
      checkOutput($sformatf("cdb_tag[%0d]", s), 64'(bus.cdb_tag[s]), 64'(expSlot[s].tag));
      checkOutput($sformatf("cdb_value[%0d]", s), bus.cdb_value[s], expSlot[s].value);
      checkOutput($sformatf("cdb_rob_tag[%0d]", s), 64'(bus.cdb_rob_tag[s]), 64'(expSlot[s].rob));
    end

`ifdef CDB_PERF_EN
    if (rstIn) begin
      modelBcast = 0;
      modelStall = 0;
    end else begin
      modelBcast = modelBcast + n;
      if (stallEvt) modelStall = modelStall + 1;
    end
    checkOutput("perf_bcast", 64'(perfBcast), 64'(modelBcast));
    checkOutput("perf_stall", 64'(perfStall), 64'(modelStall));
`else
    if (stallEvt) begin end
`endif
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    modelRr       = 0;
    pendValid     = '0;
    reset         = 1'b1;
    flushPipeline = 1'b0;
    for (int k = 0; k < NF; k++) pend[k] = '{tag: 6'd0, value: 64'd0, rob: 6'd0};
    #6;

    $display("[TB] reset");
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("reset_rr", 64'(dut.rr_ptr_q), 64'd0);

    $display("[TB] single result");
    pend[0]   = '{tag: 6'd5, value: 64'hDEAD, rob: 6'd3};
    pendValid = 4'b0001;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_valid", 64'(bus.cdb_valid), 64'b01);
    checkOutput("single_tag", 64'(bus.cdb_tag[0]), 64'd5);
    checkOutput("single_value", bus.cdb_value[0], 64'hDEAD);
    checkOutput("single_rob", 64'(bus.cdb_rob_tag[0]), 64'd3);
    applyStimulus(1'b0, 1'b0);
    checkOutput("single_idle", 64'(bus.cdb_valid), 64'b00);

    $display("[TB] four simultaneous");
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < NF; k++) pend[k] = '{tag: 6'(k + 1), value: 64'(k * 16), rob: 6'(k + 10)};
    pendValid = 4'b1111;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    checkOutput("four_t1_tag0", 64'(bus.cdb_tag[0]), 64'd1);
    checkOutput("four_t1_tag1", 64'(bus.cdb_tag[1]), 64'd2);
    applyStimulus(1'b0, 1'b0);
    checkOutput("four_t2_tag0", 64'(bus.cdb_tag[0]), 64'd3);
    checkOutput("four_t2_tag1", 64'(bus.cdb_tag[1]), 64'd4);
    checkOutput("four_rr", 64'(dut.rr_ptr_q), 64'd0);

    $display("[TB] fairness");
    for (int c = 0; c < 10; c++) begin
      for (int k = 0; k < 3; k++) if (!pendValid[k]) newResult(k);
      applyStimulus(1'b0, 1'b0);
    end
    for (int c = 0; c < 6; c++) applyStimulus(1'b0, 1'b0);

    $display("[TB] backpressure");
    for (int c = 0; c < 24; c++) begin
      for (int k = 0; k < NF; k++) if (!pendValid[k]) newResult(k);
      applyStimulus(1'b0, 1'b0);
    end

    $display("[TB] flush");
    pendValid = '0;
    pend[0]   = '{tag: 6'd9, value: 64'h9999, rob: 6'd9};
    pendValid = 4'b0001;
    applyStimulus(1'b0, 1'b1);
    checkOutput("flush_valid", 64'(bus.cdb_valid), 64'b00);
    checkOutput("flush_ready", 64'(bus.fu_ready), 64'b1111);
    for (int c = 0; c < 4; c++) applyStimulus(1'b0, 1'b0);

    $display("[TB] reset mid-stream");
    for (int c = 0; c < 12; c++) begin
      for (int k = 0; k < NF; k++) if (!pendValid[k]) newResult(k);
      applyStimulus(1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b0);
    checkOutput("midrst_ready", 64'(bus.fu_ready), 64'b0000);
    applyStimulus(1'b1, 1'b0);
    checkOutput("midrst_valid", 64'(bus.cdb_valid), 64'b00);
    checkOutput("midrst_rr", 64'(dut.rr_ptr_q), 64'd0);
    pendValid = '0;
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b0);

    $display("[TB] random");
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NF; k++) begin
        if (!pendValid[k] && $urandom_range(0, 99) < 60) newResult(k);
      end
      applyStimulus($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
